// File: rtl/bpsk_tx_scheduler_if.sv
// Byte-stream valid/ready handshake into the BPSK transmit scheduler.
interface bpsk_tx_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/bpsk_tx_scheduler.sv
// BPSK transmit scheduler: serialises bytes MSB first, one carrier period per bit.
// Optional macro BPSK_PREAMBLE_EN prepends a preamble word once per burst.
module bpsk_tx_scheduler #(
  parameter int unsigned SAMPLE_NUMBER = 256,
  parameter int unsigned SAMPLE_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH    = 8
`ifdef BPSK_PREAMBLE_EN
  ,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE = DATA_WIDTH'(8'hAA)
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  bpsk_tx_scheduler_if.slave               stream,
  output logic                             gen_en,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] signal_cnt,
  input  logic [SAMPLE_WIDTH-1:0]          sine_in,
  input  logic [SAMPLE_WIDTH-1:0]          neg_sine_in,
  output logic [SAMPLE_WIDTH-1:0]          tx_sample,
  output logic                             tx_valid,
  output logic                             busy
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_NUMBER);
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_NUMBER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SYNC     = 2'd1,
    S_SEND     = 2'd2
`ifdef BPSK_PREAMBLE_EN
    ,
    S_PREAMBLE = 2'd3
`endif
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  wrap;
  logic                  last_bit;
  logic                  tx_active;
  logic                  tx_bit;
`ifdef BPSK_PREAMBLE_EN
  logic [DATA_WIDTH-1:0] pre_shreg;
`endif

  assign wrap     = (signal_cnt == CNT_LAST);
  assign last_bit = (bit_idx == IDX_LAST);

  // Ready in idle, or exactly at the final sample of the last data bit for back-to-back reload.
  assign stream.s_ready = !rst && ((state == S_IDLE) ||
                                   ((state == S_SEND) && last_bit && wrap));

  // Which bit (if any) selects the carrier polarity this cycle.
  always_comb begin
    tx_active = 1'b0;
    tx_bit    = 1'b0;
    case (state)
      S_SEND: begin
        tx_active = 1'b1;
        tx_bit    = shreg[DATA_WIDTH-1];
      end
`ifdef BPSK_PREAMBLE_EN
      S_PREAMBLE: begin
        tx_active = 1'b1;
        tx_bit    = pre_shreg[DATA_WIDTH-1];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      gen_en    <= 1'b0;
      busy      <= 1'b0;
      tx_sample <= '0;
      tx_valid  <= 1'b0;
`ifdef BPSK_PREAMBLE_EN
      pre_shreg <= '0;
`endif
    end else begin
      tx_valid  <= tx_active;
      tx_sample <= tx_active ? (tx_bit ? neg_sine_in : sine_in) : '0;

      case (state)
        S_IDLE: begin
          if (stream.s_valid) begin
            shreg   <= stream.s_data;
            bit_idx <= '0;
            state   <= S_SYNC;
            gen_en  <= 1'b1;
            busy    <= 1'b1;
          end
        end

        // Hold until the generator wraps so every bit starts at sample index 0.
        S_SYNC: begin
          if (wrap) begin
            bit_idx <= '0;
`ifdef BPSK_PREAMBLE_EN
            pre_shreg <= PREAMBLE;
            state     <= S_PREAMBLE;
`else
            state     <= S_SEND;
`endif
          end
        end

`ifdef BPSK_PREAMBLE_EN
        S_PREAMBLE: begin
          if (wrap) begin
            if (!last_bit) begin
              pre_shreg <= pre_shreg << 1;
              bit_idx   <= bit_idx + IDX_W'(1);
            end else begin
              bit_idx <= '0;
              state   <= S_SEND;
            end
          end
        end
`endif

        S_SEND: begin
          if (wrap) begin
            if (!last_bit) begin
              shreg   <= shreg << 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end else if (stream.s_valid) begin
              shreg   <= stream.s_data;
              bit_idx <= '0;
            end else begin
              state  <= S_IDLE;
              gen_en <= 1'b0;
              busy   <= 1'b0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Directed bench for bpsk_tx_scheduler with a bit-queue reference model checked every cycle.
module tb_bpsk_tx_scheduler;

  localparam int unsigned SN = 256;
  localparam int unsigned SW = 12;
  localparam int unsigned DW = 8;
`ifdef BPSK_PREAMBLE_EN
  localparam int unsigned PRE_LEN = DW * SN;
  localparam logic [DW-1:0] PRE_PAT = 8'hAA;
`else
  localparam int unsigned PRE_LEN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    cnt = 8'd0;
  logic [SW-1:0] sine;
  logic [SW-1:0] neg_sine;
  logic          gen_en;
  logic          tx_valid;
  logic          busy;
  logic [SW-1:0] tx_sample;

  bpsk_tx_scheduler_if #(.DATA_WIDTH(DW)) stream ();

  bpsk_tx_scheduler #(
    .SAMPLE_NUMBER(SN),
    .SAMPLE_WIDTH (SW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stream     (stream),
    .gen_en     (gen_en),
    .signal_cnt (cnt),
    .sine_in    (sine),
    .neg_sine_in(neg_sine),
    .tx_sample  (tx_sample),
    .tx_valid   (tx_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Free-running stand-in generator; sample values are unique per index and polarity.
  always @(posedge clk) cnt <= cnt + 8'd1;
  assign sine     = {cnt, 4'hA};
  assign neg_sine = ~sine + 12'd1;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of bits still to transmit plus a wait-for-wrap flag.
  bit            m_busy    = 1'b0;
  bit            m_sending = 1'b0;
  bit            m_bits[$];
  logic          m_valid   = 1'b0;
  logic [SW-1:0] m_sample  = '0;

  int            run_len      = 0;
  int            last_run     = 0;
  logic [SW-1:0] first_sample = '0;
  logic [SW-1:0] last_sample  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    for (int i = DW - 1; i >= 0; i--) m_bits.push_back(b[i]);
  endtask

  task automatic compare_cycle();
    bit            exp_ready;
    logic          nxt_valid;
    logic [SW-1:0] nxt_sample;
    exp_ready = !rst && (!m_busy || (m_sending && cnt == 8'd255 && m_bits.size() == 1));
    chk("s_ready",   32'(stream.s_ready), 32'(exp_ready));
    chk("tx_valid",  32'(tx_valid),       32'(m_valid));
    chk("tx_sample", 32'(tx_sample),      32'(m_sample));
    chk("busy",      32'(busy),           32'(m_busy));
    chk("gen_en",    32'(gen_en),         32'(m_busy));

    if (tx_valid) begin
      if (run_len == 0) first_sample = tx_sample;
      last_sample = tx_sample;
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end

    nxt_valid  = 1'b0;
    nxt_sample = '0;
    if (rst) begin
      m_busy    = 1'b0;
      m_sending = 1'b0;
      m_bits.delete();
    end else if (!m_busy) begin
      if (stream.s_valid) begin
        m_busy    = 1'b1;
        m_sending = 1'b0;
`ifdef BPSK_PREAMBLE_EN
        push_byte(PRE_PAT);
`endif
        push_byte(stream.s_data);
      end
    end else if (!m_sending) begin
      if (cnt == 8'd255) m_sending = 1'b1;
    end else if (m_bits.size() != 0) begin
      nxt_valid  = 1'b1;
      nxt_sample = m_bits[0] ? neg_sine : sine;
      if (cnt == 8'd255) begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) begin
          if (stream.s_valid) push_byte(stream.s_data);
          else begin
            m_busy    = 1'b0;
            m_sending = 1'b0;
          end
        end
      end
    end
    m_valid  = nxt_valid;
    m_sample = nxt_sample;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input string name, input int limit, output logic [7:0] at_cnt);
    bit done;
    done   = 1'b0;
    at_cnt = '0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      if (stream.s_ready && stream.s_valid) begin
        done   = 1'b1;
        at_cnt = cnt;
      end
    end
    chk({name, "_handshake"}, 32'(done), 32'd1);
    tick();
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy) done = 1'b1;
    end
    chk({name, "_idle"}, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic stimulus();
    logic [7:0] acc;
    int         lat;
    stream.s_valid = 1'b0;
    stream.s_data  = '0;

    // Reset held across three edges
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy",   32'(busy),           32'd0);
      chk("rst_ready",  32'(stream.s_ready), 32'd0);
      chk("rst_txv",    32'(tx_valid),       32'd0);
      chk("rst_gen_en", 32'(gen_en),         32'd0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_rst", 32'(stream.s_ready), 32'd1);

    // Single byte A5
    tick();
    stream.s_data  = 8'hA5;
    stream.s_valid = 1'b1;
    wait_accept("acc_a5", 10, acc);
    stream.s_valid = 1'b0;
    wait_idle("a5", 3000 + int'(PRE_LEN));
    chk("run_a5",   32'(last_run),     32'(DW * SN + PRE_LEN));
    chk("first_a5", 32'(first_sample), 32'h0FF6);
    chk("last_a5",  32'(last_sample),  32'h0006);

    // Alignment: request lands while the generator is at index 100
    tick();
    stream.s_data = 8'h3C;
    do tick(); while (cnt != 8'd100);
    stream.s_valid = 1'b1;
    wait_accept("acc_3c", 4, acc);
    stream.s_valid = 1'b0;
    lat = 0;
    while (!tx_valid && lat < 3000) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("align_latency", 32'(lat), 32'd157);
`ifdef BPSK_PREAMBLE_EN
    chk("align_first", 32'(tx_sample), 32'h0FF6);
`else
    chk("align_first", 32'(tx_sample), 32'h000A);
`endif
    wait_idle("3c", 3000 + int'(PRE_LEN));
    chk("run_3c",  32'(last_run),    32'(DW * SN + PRE_LEN));
    chk("last_3c", 32'(last_sample), 32'h0FFA);

    // Back-to-back FF then 00 with valid held
    tick();
    stream.s_data  = 8'hFF;
    stream.s_valid = 1'b1;
    wait_accept("acc_ff", 4, acc);
    stream.s_data = 8'h00;
    wait_accept("acc_00", 2400 + int'(PRE_LEN), acc);
    chk("b2b_accept_cnt", 32'(acc), 32'd255);
    stream.s_valid = 1'b0;
    wait_idle("b2b", 3000);
    chk("run_b2b",   32'(last_run),     32'(2 * DW * SN + PRE_LEN));
    chk("first_b2b", 32'(first_sample), 32'h0FF6);
    chk("last_b2b",  32'(last_sample),  32'h0FFA);

    // Reset in the middle of the fourth bit
    tick();
    stream.s_data  = 8'h96;
    stream.s_valid = 1'b1;
    wait_accept("acc_96", 4, acc);
    stream.s_valid = 1'b0;
    for (int i = 0; i < 5000 && run_len != int'(PRE_LEN + 3 * SN + 49); i++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_reached", 32'(run_len), 32'(PRE_LEN + 3 * SN + 49));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_txv",    32'(tx_valid), 32'd0);
    chk("mid_rst_gen_en", 32'(gen_en),   32'd0);
    chk("mid_rst_busy",   32'(busy),     32'd0);

    // Clean byte after the abort
    tick();
    stream.s_data  = 8'h5A;
    stream.s_valid = 1'b1;
    wait_accept("acc_5a", 4, acc);
    stream.s_valid = 1'b0;
    wait_idle("5a", 3000 + int'(PRE_LEN));
    chk("run_5a",  32'(last_run),    32'(DW * SN + PRE_LEN));
    chk("last_5a", 32'(last_sample), 32'h0FFA);
`ifdef BPSK_PREAMBLE_EN
    chk("first_5a", 32'(first_sample), 32'h0FF6);
`else
    chk("first_5a", 32'(first_sample), 32'h000A);
`endif

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
      stimulus();
    join
  end

endmodule
